// File: rtl/cnn_infer_scheduler_if.sv
// Purpose: signal bundle between the host sample stream, CNN input BRAM write port, CNN control and frame reports.
// Latency: none, wires only.
// Backpressure: o_s_ready comes from the scheduler (slave side); the master side drives every i_* signal.
// Ports (all scheduler-relative names):
//   i_s_valid/o_s_ready/i_s_data/i_s_last  host sample stream
//   o_bram_we/o_bram_addr/o_bram_wdata     CNN input BRAM write port
//   o_start_inference/i_cnn_done/i_spike_fire  CNN control and spike events
//   o_frame_done/o_frame_id/o_spike_count/o_err_len/o_err_timeout/o_busy  status
// Parameters must match the ones given to cnn_infer_scheduler.
interface cnn_infer_scheduler_if #(
  parameter int IMG_H      = 8,
  parameter int IMG_W      = 9,
  parameter int IMG_C      = 4,
  parameter int DATA_W     = 8,
  parameter int FLAT_LEN   = 320,
  parameter int FRAME_ID_W = 8
);
  localparam int ADDR_W = $clog2(IMG_H * IMG_W * IMG_C);
  localparam int CNT_W  = $clog2(FLAT_LEN + 1);

  logic              i_s_valid;
  logic              o_s_ready;
  logic [DATA_W-1:0] i_s_data;
  logic              i_s_last;
  logic              o_bram_we;
  logic [ADDR_W-1:0] o_bram_addr;
  logic [DATA_W-1:0] o_bram_wdata;
  logic              o_start_inference;
  logic              i_cnn_done;
  logic              i_spike_fire;
  logic              o_frame_done;
  logic [FRAME_ID_W-1:0] o_frame_id;
  logic [CNT_W-1:0]  o_spike_count;
  logic              o_err_len;
  logic              o_err_timeout;
  logic              o_busy;

  modport master (
    output i_s_valid, i_s_data, i_s_last, i_cnn_done, i_spike_fire,
    input  o_s_ready, o_bram_we, o_bram_addr, o_bram_wdata, o_start_inference,
           o_frame_done, o_frame_id, o_spike_count, o_err_len, o_err_timeout, o_busy
  );

  modport slave (
    input  i_s_valid, i_s_data, i_s_last, i_cnn_done, i_spike_fire,
    output o_s_ready, o_bram_we, o_bram_addr, o_bram_wdata, o_start_inference,
           o_frame_done, o_frame_id, o_spike_count, o_err_len, o_err_timeout, o_busy
  );
endinterface

// File: rtl/cnn_infer_scheduler.sv
// Purpose: frame sequencer - loads a frame into CNN input BRAM, starts inference, counts spikes, reports per frame.
// Latency: BRAM write one cycle after handshake; start pulse one cycle after last beat; report one cycle after done.
// Backpressure: o_s_ready high only while a frame may be loaded; held low during start/BRAM read and until report.
// Ports: clk, rst_n (async active-low), bus (cnn_infer_scheduler_if.slave, see interface header).
// Option: define CNN_SCHED_OVERLAP_EN to allow loading the next frame during WAIT_DONE and REPORT.
module cnn_infer_scheduler #(
  parameter int IMG_H          = 8,
  parameter int IMG_W          = 9,
  parameter int IMG_C          = 4,
  parameter int DATA_W         = 8,
  parameter int FLAT_LEN       = 320,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int FRAME_ID_W     = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  cnn_infer_scheduler_if.slave bus
);
  localparam int N      = IMG_H * IMG_W * IMG_C;
  localparam int P      = IMG_H * IMG_W;
  localparam int ADDR_W = $clog2(N);
  localparam int CNT_W  = $clog2(FLAT_LEN + 1);
  localparam int WIN_W  = $clog2(P + 1);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {LOAD, START, READ_WIN, WAIT_DONE, REPORT} state_t;

  state_t                state;
  logic [ADDR_W-1:0]     beat_cnt;
  logic [WIN_W-1:0]      win_cnt;
  logic [WD_W-1:0]       wd_cnt;
  logic [CNT_W-1:0]      spike_cnt;
  logic [FRAME_ID_W-1:0] frame_id;
`ifdef CNN_SCHED_OVERLAP_EN
  logic                  pending;
`endif

  logic             load_en;
  logic             beat;
  logic             at_end;
  logic             frame_complete;
  logic             len_err;
  logic             spike_win;
  logic [CNT_W-1:0] spike_nxt;
  logic             wd_expired;

`ifdef CNN_SCHED_OVERLAP_EN
  // A completed-but-unstarted frame occupies the BRAM, so stop accepting until it is started.
  assign load_en = (state == LOAD) ||
                   (((state == WAIT_DONE) || (state == REPORT)) && !pending);
`else
  assign load_en = (state == LOAD);
`endif

  assign bus.o_s_ready = load_en;
  assign bus.o_busy    = (state != LOAD);

  assign beat           = bus.i_s_valid && load_en;
  assign at_end         = (beat_cnt == ADDR_W'(N - 1));
  assign frame_complete = beat && bus.i_s_last && at_end;
  // Early last, or a full-length frame without last: either way the frame is discarded.
  assign len_err        = beat && (bus.i_s_last != at_end);

  // Counting window runs from READ_WIN entry through the cycle done is seen.
  assign spike_win  = (state == READ_WIN) || (state == WAIT_DONE);
  assign spike_nxt  = (spike_win && bus.i_spike_fire && (spike_cnt != CNT_W'(FLAT_LEN)))
                      ? spike_cnt + 1'b1 : spike_cnt;
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= LOAD;
      beat_cnt              <= '0;
      win_cnt               <= '0;
      wd_cnt                <= '0;
      spike_cnt             <= '0;
      frame_id              <= '0;
`ifdef CNN_SCHED_OVERLAP_EN
      pending               <= 1'b0;
`endif
      bus.o_bram_we         <= 1'b0;
      bus.o_bram_addr       <= '0;
      bus.o_bram_wdata      <= '0;
      bus.o_start_inference <= 1'b0;
      bus.o_frame_done      <= 1'b0;
      bus.o_frame_id        <= '0;
      bus.o_spike_count     <= '0;
      bus.o_err_len         <= 1'b0;
      bus.o_err_timeout     <= 1'b0;
    end else begin
      bus.o_start_inference <= 1'b0;
      bus.o_frame_done      <= 1'b0;
      bus.o_err_timeout     <= 1'b0;
      bus.o_err_len         <= len_err;
      bus.o_bram_we         <= beat;
      spike_cnt             <= spike_nxt;

      // Every accepted beat is written, including those of a frame later found malformed.
      if (beat) begin
        bus.o_bram_addr  <= beat_cnt;
        bus.o_bram_wdata <= bus.i_s_data;
        if (frame_complete || len_err) beat_cnt <= '0;
        else                           beat_cnt <= beat_cnt + 1'b1;
      end

      case (state)
        LOAD: begin
          if (frame_complete) begin
            state                 <= START;
            bus.o_start_inference <= 1'b1;
          end
        end
        START: begin
          state   <= READ_WIN;
          win_cnt <= '0;
        end
        READ_WIN: begin
          if (win_cnt == WIN_W'(P)) begin
            state  <= WAIT_DONE;
            wd_cnt <= '0;
`ifdef CNN_SCHED_OVERLAP_EN
            beat_cnt <= '0;
`endif
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
`ifdef CNN_SCHED_OVERLAP_EN
          if (frame_complete) pending <= 1'b1;
`endif
          // Done on the final watchdog cycle still counts as a normal completion.
          // The report strobe and any timeout pulse land in the same (REPORT) cycle.
          if (bus.i_cnn_done || wd_expired) begin
            state                 <= REPORT;
            bus.o_frame_done      <= 1'b1;
            bus.o_frame_id        <= frame_id;
            bus.o_spike_count     <= spike_nxt;
            bus.o_err_timeout     <= !bus.i_cnn_done;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        REPORT: begin
          frame_id  <= frame_id + 1'b1;
          spike_cnt <= '0;
          wd_cnt    <= '0;
`ifdef CNN_SCHED_OVERLAP_EN
          if (pending || frame_complete) begin
            state                 <= START;
            bus.o_start_inference <= 1'b1;
            pending               <= 1'b0;
          end else begin
            state <= LOAD;
          end
`else
          state <= LOAD;
`endif
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_infer_scheduler.sv
`timescale 1ns/1ps
module tb_cnn_infer_scheduler;
  localparam int N = 288;
`ifdef CNN_SCHED_OVERLAP_EN
  localparam int OVL = 1;
`else
  localparam int OVL = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cnn_infer_scheduler_if #(.IMG_H(8), .IMG_W(9), .IMG_C(4), .DATA_W(8),
                           .FLAT_LEN(320), .FRAME_ID_W(8)) bif ();

  cnn_infer_scheduler #(.IMG_H(8), .IMG_W(9), .IMG_C(4), .DATA_W(8), .FLAT_LEN(320),
                        .TIMEOUT_CYCLES(4096), .FRAME_ID_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int n_pass = 0;
  int n_total = 0;

  // Event monitor, sampled mid-cycle.
  int wr_cnt = 0, start_cnt = 0, errlen_cnt = 0, to_cnt = 0, fd_cnt = 0;
  int mem [N];
  always @(negedge clk) begin
    if (bif.o_bram_we) begin
      wr_cnt++;
      if (int'(bif.o_bram_addr) < N) mem[int'(bif.o_bram_addr)] = int'(bif.o_bram_wdata);
    end
    if (bif.o_start_inference) start_cnt++;
    if (bif.o_err_len)         errlen_cnt++;
    if (bif.o_err_timeout)     to_cnt++;
    if (bif.o_frame_done)      fd_cnt++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mem_bad(input int n, input int base);
    int bad = 0;
    for (int k = 0; k < n; k++)
      if (mem[k] != ((k + base) % 256)) bad++;
    return bad;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_ready"},  bif.o_s_ready, 1);
    chk({tag, "_busy"},   bif.o_busy, 0);
    chk({tag, "_we"},     bif.o_bram_we, 0);
    chk({tag, "_addr"},   bif.o_bram_addr, 0);
    chk({tag, "_wdata"},  bif.o_bram_wdata, 0);
    chk({tag, "_start"},  bif.o_start_inference, 0);
    chk({tag, "_fdone"},  bif.o_frame_done, 0);
    chk({tag, "_id"},     bif.o_frame_id, 0);
    chk({tag, "_cnt"},    bif.o_spike_count, 0);
    chk({tag, "_errlen"}, bif.o_err_len, 0);
    chk({tag, "_errto"},  bif.o_err_timeout, 0);
  endtask

  // Sends beats k=0..nbeats-1 with data (k+base), last on beat last_at.
  // Returns at the first sample point after the final handshake edge.
  task automatic send_frame(input int nbeats, input int last_at, input int base,
                            input int gaps, output bit ok);
    int k = 0;
    int cyc = 0;
    bit hs;
    ok = 1'b1;
    while (k < nbeats) begin
      bif.i_s_valid = !((gaps != 0) && (cyc % 5 == 2));
      bif.i_s_data  = 8'(k + base);
      bif.i_s_last  = (k == last_at);
      hs = bif.i_s_valid && bif.o_s_ready;
      tick();
      if (hs) k++;
      cyc++;
      if (cyc > 2000) begin
        ok = 1'b0;
        break;
      end
    end
    bif.i_s_valid = 1'b0;
    bif.i_s_last  = 1'b0;
    bif.i_s_data  = '0;
  endtask

  // Entered in the START cycle; walks START + 73 READ_WIN cycles, firing spikes on
  // cycles 0..rw (cycle 0 is START and must be ignored). Ends in the first WAIT_DONE cycle.
  task automatic to_wait(input int rw, output int rdy_hi);
    rdy_hi = 0;
    for (int c = 0; c < 74; c++) begin
      bif.i_spike_fire = (rw > 0) && (c <= rw);
      if (bif.o_s_ready) rdy_hi++;
      tick();
    end
    bif.i_spike_fire = 1'b0;
  endtask

  // From the first WAIT_DONE cycle: wd spike pulses on even offsets, done at done_at
  // (negative: never), optional spike alongside done. Returns cycles until the report.
  task automatic finish(input int wd, input int sod, input int done_at, output int off);
    off = 0;
    while (!bif.o_frame_done && off < 5000) begin
      bif.i_spike_fire = ((off < 2 * wd) && (off % 2 == 0)) || ((sod != 0) && (off == done_at));
      bif.i_cnn_done   = (off == done_at);
      tick();
      off++;
    end
    bif.i_spike_fire = 1'b0;
    bif.i_cnn_done   = 1'b0;
  endtask

  typedef struct {
    int nbeats; int last_at; int base; int gaps;
    int rw; int wd; int sod; int done_at;
    int exp_err; int exp_off; int exp_cnt; int exp_id; int exp_to;
  } vec_t;

  vec_t vecs [8];
  vec_t v;
  int   s_wr, s_st, s_el, s_to, s_fd, rh, off;
  bit   ok;
  string pfx;

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    //            nbeats last base gaps  rw  wd sod done   err  off  cnt id to
    vecs[0] = '{288, 287,   0, 0,   0,   5, 1,   12,   0,   13,   6, 0, 0};
    vecs[1] = '{288, 287,  17, 1,   3,   0, 0,    0,   0,    1,   3, 1, 0};
    vecs[2] = '{100,  99,  50, 0,   0,   0, 0,    0,   1,    0,   0, 0, 0};
    vecs[3] = '{288,  -1,   5, 1,   0,   0, 0,    0,   1,    0,   0, 0, 0};
    vecs[4] = '{288, 287, 200, 0,   0, 330, 1,  700,   0,  701, 320, 2, 0};
    vecs[5] = '{288, 287,   3, 0,   2,   7, 0,   -1,   0, 4096,   9, 3, 1};
    vecs[6] = '{288, 287,   9, 1,   0,   0, 1, 4095,   0, 4096,   1, 4, 0};
    vecs[7] = '{288, 287,   1, 0,  73,   0, 0,    3,   0,    4,  73, 5, 0};

    bif.i_s_valid = 1'b0; bif.i_s_data = '0; bif.i_s_last = 1'b0;
    bif.i_cnn_done = 1'b0; bif.i_spike_fire = 1'b0;
    #1 rst_n = 1'b0;
    tick(); tick();
    check_idle("rst");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      pfx = $sformatf("v%0d", i);
      s_wr = wr_cnt; s_st = start_cnt; s_el = errlen_cnt; s_to = to_cnt; s_fd = fd_cnt;
      send_frame(v.nbeats, v.last_at, v.base, v.gaps, ok);
      chk({pfx, "_load_bound"}, ok, 1);
      if (v.exp_err != 0) begin
        chk({pfx, "_errlen"}, bif.o_err_len, 1);
        chk({pfx, "_ready"}, bif.o_s_ready, 1);
        tick(); tick(); tick();
        chk({pfx, "_no_start"}, start_cnt - s_st, 0);
        chk({pfx, "_errlen_once"}, errlen_cnt - s_el, 1);
      end else begin
        chk({pfx, "_start"}, bif.o_start_inference, 1);
        chk({pfx, "_noerr"}, bif.o_err_len, 0);
        to_wait(v.rw, rh);
        chk({pfx, "_rdy_low_74"}, rh, 0);
        chk({pfx, "_rdy_in_wait"}, bif.o_s_ready, OVL);
        finish(v.wd, v.sod, v.done_at, off);
        chk({pfx, "_report_cycle"}, off, v.exp_off);
        chk({pfx, "_frame_done"}, bif.o_frame_done, 1);
        chk({pfx, "_id"}, bif.o_frame_id, v.exp_id);
        chk({pfx, "_cnt"}, bif.o_spike_count, v.exp_cnt);
        chk({pfx, "_timeout"}, bif.o_err_timeout, v.exp_to);
        tick();
        chk({pfx, "_fd_pulse"}, bif.o_frame_done, 0);
        chk({pfx, "_cnt_hold"}, bif.o_spike_count, v.exp_cnt);
        chk({pfx, "_ready_back"}, bif.o_s_ready, 1);
        chk({pfx, "_busy_back"}, bif.o_busy, 0);
        chk({pfx, "_start_once"}, start_cnt - s_st, 1);
        chk({pfx, "_report_once"}, fd_cnt - s_fd, 1);
        chk({pfx, "_to_pulses"}, to_cnt - s_to, v.exp_to);
      end
      chk({pfx, "_writes"}, wr_cnt - s_wr, v.nbeats);
      chk({pfx, "_wdata"}, mem_bad(v.nbeats, v.base), 0);
    end

    // Reset in the middle of WAIT_DONE: immediate idle, no report, id restarts.
    send_frame(288, 287, 77, 0, ok);
    chk("mid_load_bound", ok, 1);
    to_wait(0, rh);
    bif.i_spike_fire = 1'b1;
    tick(); tick(); tick();
    s_fd = fd_cnt; s_to = to_cnt; s_el = errlen_cnt;
    rst_n = 1'b0;
    #1;
    check_idle("mid_rst");
    bif.i_spike_fire = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_no_report", fd_cnt - s_fd, 0);
    chk("mid_rst_no_err", (to_cnt - s_to) + (errlen_cnt - s_el), 0);
    send_frame(288, 287, 88, 0, ok);
    chk("post_rst_start", bif.o_start_inference, 1);
    to_wait(0, rh);
    finish(2, 0, 5, off);
    chk("post_rst_report_cycle", off, 6);
    chk("post_rst_id", bif.o_frame_id, 0);
    chk("post_rst_cnt", bif.o_spike_count, 2);
    tick();
    chk("post_rst_wdata", mem_bad(288, 88), 0);

`ifdef CNN_SCHED_OVERLAP_EN
    // Next frame loaded while the current one waits for done.
    send_frame(288, 287, 120, 0, ok);
    chk("ovl_first_start", bif.o_start_inference, 1);
    to_wait(0, rh);
    chk("ovl_ready_wait", bif.o_s_ready, 1);
    s_st = start_cnt;
    send_frame(288, 287, 130, 0, ok);
    chk("ovl_load_bound", ok, 1);
    chk("ovl_ready_pending", bif.o_s_ready, 0);
    chk("ovl_no_early_start", start_cnt - s_st, 0);
    bif.i_cnn_done = 1'b1;
    tick();
    bif.i_cnn_done = 1'b0;
    chk("ovl_report", bif.o_frame_done, 1);
    chk("ovl_report_id", bif.o_frame_id, 1);
    tick();
    chk("ovl_start_after_report", bif.o_start_inference, 1);
    chk("ovl_wdata", mem_bad(288, 130), 0);
    to_wait(0, rh);
    finish(0, 0, 1, off);
    chk("ovl_second_id", bif.o_frame_id, 2);
    chk("ovl_second_cnt", bif.o_spike_count, 0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cnn_infer_scheduler.md
# cnn_infer_scheduler

Frame-level sequencer for the streaming CNN inference pipeline. Accepts input frames from a host over a valid/ready stream and writes them into the CNN input BRAM write port. Issues the single-cycle inference start, blocks BRAM writes while the CNN streams pixels, and watches for completion with a watchdog. Counts encoder spikes per frame and reports a per-frame summary.

## Interface
Parameters:
- IMG_H, 8, input image height
- IMG_W, 9, input image width
- IMG_C, 4, input channels
- DATA_W, 8, sample width
- FLAT_LEN, 320, maximum spikes per frame (encoder vector length)
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT_DONE
- FRAME_ID_W, 8, frame id width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_s_valid  in  1  host sample valid
- o_s_ready  out  1  host sample ready
- i_s_data  in  DATA_W  signed sample; channel-major, row-major within channel
- i_s_last  in  1  marks final sample of a frame
- o_bram_we  out  1  CNN input BRAM write enable
- o_bram_addr  out  $clog2(IMG_H*IMG_W*IMG_C)  BRAM write address
- o_bram_wdata  out  DATA_W  BRAM write data
- o_start_inference  out  1  one-cycle start pulse to CNN
- i_cnn_done  in  1  CNN/encoder last-pixel-sent pulse
- i_spike_fire  in  1  accepted spike (encoder valid AND ack)
- o_frame_done  out  1  one-cycle frame report strobe
- o_frame_id  out  FRAME_ID_W  id of reported frame
- o_spike_count  out  $clog2(FLAT_LEN+1)  spikes in reported frame
- o_err_len  out  1  one-cycle pulse: malformed frame discarded
- o_err_timeout  out  1  one-cycle pulse: watchdog expired
- o_busy  out  1  high in any state other than LOAD

## Operation
- N = IMG_H*IMG_W*IMG_C (288); P = IMG_H*IMG_W (72).
- States: LOAD, START, READ_WIN, WAIT_DONE, REPORT. Reset state LOAD.
- LOAD: o_s_ready=1. Each handshake writes sample k to address k (k = beat count, 0..N-1).
- Beat with i_s_last at k==N-1 -> START.
- i_s_last at k<N-1, or beat k==N-1 without i_s_last -> o_err_len pulse, frame discarded, k reset to 0, stay in LOAD. BRAM writes already issued are not undone.
- START: o_start_inference=1 for exactly one cycle -> READ_WIN.
- READ_WIN: o_s_ready=0 for P+1 cycles (CNN reading the BRAM) -> WAIT_DONE.
- WAIT_DONE: the spike counter increments on i_spike_fire and saturates at FLAT_LEN. The watchdog counts cycles from entry.
  - i_cnn_done -> REPORT.
  - Watchdog reaching TIMEOUT_CYCLES without done -> o_err_timeout pulse, then REPORT.
- REPORT: o_frame_done=1 for one cycle. o_frame_id and o_spike_count update in the same cycle and hold until the next report. Frame id increments modulo 2^FRAME_ID_W after report. Spike counter and watchdog clear. Next state LOAD (or START, see Configuration).
- Spike counting window: from entry to READ_WIN through the cycle i_cnn_done is seen, inclusive. i_spike_fire is ignored in all other states.
- Simultaneous events:
  - done and timeout in the same cycle: done wins, no error.
  - spike and done in the same cycle: spike counted.
  - i_cnn_done outside WAIT_DONE: ignored.

## Timing
- Reset values:
  - o_s_ready=1 (combinational decode of LOAD).
  - All other outputs 0; frame id 0; counters 0.
- BRAM write path is registered: a handshake at edge t drives o_bram_we/addr/wdata during cycle t+1.
- The last-beat handshake at edge t gives START during cycle t+1, so the final write commits at the same edge the CNN samples start.
- Start-to-ready latency: o_s_ready returns P+2 cycles after the start pulse (non-overlap mode: after REPORT).
- Reset mid-operation: immediate return to LOAD; partial frame and counts discarded; no report, no error pulses.

## Configuration
- CNN_SCHED_OVERLAP_EN defined:
  - Loading of the next frame is allowed during WAIT_DONE and REPORT (o_s_ready=1 there).
  - A frame completed before REPORT sets a pending flag and o_s_ready drops to 0.
  - REPORT then goes directly to START.
  - Beat count restarts at 0 on entry to WAIT_DONE.
- Not defined: o_s_ready=1 only in LOAD; REPORT always returns to LOAD.

## Test plan
- Reset release, 288 beats (data=k[7:0]), last on beat 288 -> 288 writes to addr 0..287 with wdata=k[7:0]; one start pulse one cycle after the final handshake; ready low for 73 cycles.
- In WAIT_DONE, 5 i_spike_fire pulses, then i_cnn_done with a simultaneous spike -> o_frame_done with o_spike_count=6, o_frame_id=0; next frame reports id=1.
- i_s_last on beat 100 -> o_err_len pulse, no start; a following correct 288-beat frame starts normally.
- No i_cnn_done for 4096 cycles -> o_err_timeout pulse, then o_frame_done with accumulated count; return to LOAD.
- With CNN_SCHED_OVERLAP_EN, full second frame loaded during WAIT_DONE -> ready low after its last beat; start pulse in the cycle after REPORT.
- rst_n asserted mid-WAIT_DONE -> all outputs 0 and o_s_ready=1 immediately; o_frame_id restarts at 0.
